// File: rtl/regfile_pkg.sv
// Shared helpers and register-map constants for the multi-port register file.
// The default map mirrors the 6502 architectural registers.
package regfile_pkg;

  localparam int REG_A = 0;
  localparam int REG_X = 1;
  localparam int REG_Y = 2;
  localparam int REG_S = 3;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Address width for n entries; never narrower than one bit so DEPTH=2 still gets a real address.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_readport.sv
// One read port: entry mux, optional same-cycle write forwarding with port-1 priority,
// and an optional output register.
module regfile_readport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NWRITE   = 1,
  parameter int BYPASS   = 1,
  parameter int REG_READ = 0,
  parameter int ADDRW    = clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDRW-1:0]              raddr,
  input  logic [DEPTH-1:0][WIDTH-1:0]   mem,
  input  logic [NWRITE-1:0]             we,
  input  logic [NWRITE*ADDRW-1:0]       waddr,
  input  logic [NWRITE*WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]              rdata
);

  logic             in_range;
  logic [WIDTH-1:0] read_val;
  logic             unused_sink;

  assign in_range = (32'(raddr) < DEPTH);

  // Later write ports overwrite earlier matches, giving port 1 priority on a collision.
  // Out-of-range addresses never forward, matching the dropped write.
  always_comb begin
    read_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDRW'(i)) read_val = mem[i];
    end
    if (BYPASS != 0 && in_range) begin
      for (int p = 0; p < NWRITE; p++) begin
        if (we[p] && (waddr[p*ADDRW +: ADDRW] == raddr)) read_val = wdata[p*WIDTH +: WIDTH];
      end
    end
  end

  if (REG_READ != 0) begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset) rdata <= '0;
      else       rdata <= read_val;
    end
  end else begin : g_comb
    assign rdata = read_val;
  end

  assign unused_sink = ^{clk, reset};

endmodule

// File: rtl/regfile_mp.sv
// Parametrised flop-based register file: prioritised synchronous writes, per-entry dirty
// tracking, a write-collision flag and NREAD independent read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int BYPASS   = 1,
  parameter int REG_READ = 0,
  localparam int ADDRW   = clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDRW-1:0]  waddr,
  input  logic [NWRITE*WIDTH-1:0]  wdata,
  input  logic [NREAD*ADDRW-1:0]   raddr,
  output logic [NREAD*WIDTH-1:0]   rdata,
  output logic [DEPTH-1:0]         dirty,
  input  logic [DEPTH-1:0]         dirty_clr,
  output logic                     collision
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0][WIDTH-1:0] mem_next;
  logic [DEPTH-1:0]            written;
  logic                        collide;

  // Decoding against real entry indices drops out-of-range writes for free;
  // iterating ports in ascending order lets port 1 win a same-address write.
  always_comb begin
    mem_next = mem;
    written  = '0;
    for (int p = 0; p < NWRITE; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[p] && (waddr[p*ADDRW +: ADDRW] == ADDRW'(i))) begin
          mem_next[i] = wdata[p*WIDTH +: WIDTH];
          written[i]  = 1'b1;
        end
      end
    end
  end

  if (NWRITE == 2) begin : g_collide
    assign collide = we[0] && we[1]
                  && (waddr[0 +: ADDRW] == waddr[ADDRW +: ADDRW])
                  && (32'(waddr[0 +: ADDRW]) < DEPTH);
  end else begin : g_no_collide
    assign collide = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem       <= '0;
      dirty     <= '0;
      collision <= 1'b0;
    end else begin
      mem       <= mem_next;
      dirty     <= (dirty & ~dirty_clr) | written;
      collision <= collide;
    end
  end

  for (genvar r = 0; r < NREAD; r++) begin : g_read
    regfile_readport #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .NWRITE   (NWRITE),
      .BYPASS   (BYPASS),
      .REG_READ (REG_READ),
      .ADDRW    (ADDRW)
    ) u_rd (
      .clk   (clk),
      .reset (reset),
      .raddr (raddr[r*ADDRW +: ADDRW]),
      .mem   (mem),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .rdata (rdata[r*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: four configurations exercised from one linear sequence
// with hand-computed expectations.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // u_a: 2W/2R, bypass, combinational read
  logic [1:0]  a_we;
  logic [3:0]  a_waddr;
  logic [15:0] a_wdata;
  logic [3:0]  a_raddr;
  logic [15:0] a_rdata;
  logic [3:0]  a_dirty, a_clr;
  logic        a_col;

  // u_b: 1W/2R, no bypass
  logic [0:0]  b_we;
  logic [1:0]  b_waddr;
  logic [7:0]  b_wdata;
  logic [3:0]  b_raddr;
  logic [15:0] b_rdata;
  logic [3:0]  b_dirty, b_clr;
  logic        b_col;

  // u_c: 1W/2R, registered read
  logic [0:0]  c_we;
  logic [1:0]  c_waddr;
  logic [7:0]  c_wdata;
  logic [3:0]  c_raddr;
  logic [15:0] c_rdata;
  logic [3:0]  c_dirty, c_clr;
  logic        c_col;

  // u_d: DEPTH=6, WIDTH=16, 3 read ports, 2 write ports
  logic [1:0]  d_we;
  logic [5:0]  d_waddr;
  logic [31:0] d_wdata;
  logic [8:0]  d_raddr;
  logic [47:0] d_rdata;
  logic [5:0]  d_dirty, d_clr;
  logic        d_col;

  int pass_cnt = 0;
  int total_cnt = 0;

  regfile_mp #(.WIDTH(8), .DEPTH(4), .NREAD(2), .NWRITE(2), .BYPASS(1), .REG_READ(0)) u_a (
    .clk(clk), .reset(reset), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .raddr(a_raddr), .rdata(a_rdata), .dirty(a_dirty), .dirty_clr(a_clr), .collision(a_col));

  regfile_mp #(.WIDTH(8), .DEPTH(4), .NREAD(2), .NWRITE(1), .BYPASS(0), .REG_READ(0)) u_b (
    .clk(clk), .reset(reset), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .raddr(b_raddr), .rdata(b_rdata), .dirty(b_dirty), .dirty_clr(b_clr), .collision(b_col));

  regfile_mp #(.WIDTH(8), .DEPTH(4), .NREAD(2), .NWRITE(1), .BYPASS(1), .REG_READ(1)) u_c (
    .clk(clk), .reset(reset), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
    .raddr(c_raddr), .rdata(c_rdata), .dirty(c_dirty), .dirty_clr(c_clr), .collision(c_col));

  regfile_mp #(.WIDTH(16), .DEPTH(6), .NREAD(3), .NWRITE(2), .BYPASS(1), .REG_READ(0)) u_d (
    .clk(clk), .reset(reset), .we(d_we), .waddr(d_waddr), .wdata(d_wdata),
    .raddr(d_raddr), .rdata(d_rdata), .dirty(d_dirty), .dirty_clr(d_clr), .collision(d_col));

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_we = '0; a_waddr = '0; a_wdata = '0; a_raddr = '0; a_clr = '0;
    b_we = '0; b_waddr = '0; b_wdata = '0; b_raddr = '0; b_clr = '0;
    c_we = '0; c_waddr = '0; c_wdata = '0; c_raddr = '0; c_clr = '0;
    d_we = '0; d_waddr = '0; d_wdata = '0; d_raddr = '0; d_clr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("initial_dirty", 64'(a_dirty), 64'h0);

    // Fill all entries with 0x5A, finishing on a same-address write to raise collision
    a_we = 2'b11; a_wdata = 16'h5A5A;
    a_waddr = {2'd1, 2'd0}; tick();
    a_waddr = {2'd3, 2'd2}; tick();
    a_waddr = {2'd3, 2'd3}; tick();
    a_we = 2'b00;
    a_raddr = {2'd3, 2'd0};
    #1;
    check_output("prefill_rdata", 64'(a_rdata), 64'h5A5A);
    check_output("prefill_dirty", 64'(a_dirty), 64'hF);
    check_output("prefill_collision", 64'(a_col), 64'h1);

    // Asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    check_output("async_rst_rdata", 64'(a_rdata), 64'h0);
    check_output("async_rst_dirty", 64'(a_dirty), 64'h0);
    check_output("async_rst_collision", 64'(a_col), 64'h0);
    tick();
    reset = 1'b0;

    // Collision: port 1 wins, flag pulses for one cycle
    a_we = 2'b11; a_waddr = {2'd2, 2'd2}; a_wdata = {8'h22, 8'h11};
    a_raddr = {2'd2, 2'd2};
    #1;
    check_output("collide_bypass", 64'(a_rdata), 64'h2222);
    tick();
    a_we = 2'b00;
    #1;
    check_output("collide_stored", 64'(a_rdata), 64'h2222);
    check_output("collide_flag", 64'(a_col), 64'h1);
    check_output("collide_dirty", 64'(a_dirty), 64'h4);
    tick();
    check_output("collide_flag_drop", 64'(a_col), 64'h0);

    // Same-cycle write forwarding vs. no-bypass
    a_we = 2'b01; a_waddr = {2'd0, 2'd1}; a_wdata = {8'h00, 8'h7F};
    a_raddr = {2'd2, 2'd1};
    b_we = 1'b1; b_waddr = 2'd1; b_wdata = 8'h7F;
    b_raddr = {2'd0, 2'd1};
    #1;
    check_output("bypass_same_cycle", 64'(a_rdata), 64'h227F);
    check_output("nobypass_old", 64'(b_rdata), 64'h0000);
    tick();
    a_we = 2'b00; b_we = 1'b0;
    #1;
    check_output("bypass_after_edge", 64'(a_rdata), 64'h227F);
    check_output("nobypass_after_edge", 64'(b_rdata), 64'h007F);

    // Registered read latency
    c_we = 1'b1; c_waddr = 2'd3; c_wdata = 8'h33; c_raddr = {2'd0, 2'd0};
    tick();
    c_we = 1'b0; c_raddr = {2'd3, 2'd3};
    #1;
    check_output("regread_before_edge", 64'(c_rdata), 64'h0000);
    tick();
    check_output("regread_after_edge", 64'(c_rdata), 64'h3333);
    c_we = 1'b1; c_waddr = 2'd2; c_wdata = 8'h44; c_raddr = {2'd3, 2'd2};
    #1;
    check_output("regread_bypass_hold", 64'(c_rdata), 64'h3333);
    tick();
    c_we = 1'b0;
    #1;
    check_output("regread_bypass", 64'(c_rdata), 64'h3344);

    // Dirty: write beats clear, then clear takes effect
    a_we = 2'b01; a_waddr = {2'd0, 2'd0}; a_wdata = {8'h00, 8'h01}; a_clr = 4'b0001;
    tick();
    a_we = 2'b00;
    #1;
    check_output("dirty_write_wins", 64'(a_dirty), 64'h7);
    tick();
    check_output("dirty_clear", 64'(a_dirty), 64'h6);
    a_clr = 4'b0110;
    tick();
    a_clr = 4'b0000;
    check_output("dirty_clear_multi", 64'(a_dirty), 64'h0);

    // Non-power-of-two depth, wide data, three read ports
    d_we = 2'b01; d_waddr = {3'd0, 3'd5}; d_wdata = {16'h0000, 16'hBEEF};
    d_raddr = {3'd5, 3'd5, 3'd5};
    tick();
    d_we = 2'b00;
    #1;
    check_output("d_three_ports", 64'(d_rdata), 64'hBEEF_BEEF_BEEF);
    check_output("d_dirty_5", 64'(d_dirty), 64'h20);
    d_we = 2'b10; d_waddr = {3'd7, 3'd0}; d_wdata = {16'h1234, 16'h0000};
    d_raddr = {3'd6, 3'd7, 3'd5};
    #1;
    check_output("d_oor_no_bypass", 64'(d_rdata), 64'h0000_0000_BEEF);
    tick();
    d_we = 2'b00;
    #1;
    check_output("d_oor_write_dropped", 64'(d_dirty), 64'h20);
    check_output("d_oor_read_zero", 64'(d_rdata), 64'h0000_0000_BEEF);
    d_raddr = {3'd0, 3'd1, 3'd4};
    #1;
    check_output("d_no_alias", 64'(d_rdata), 64'h0);
    check_output("d_no_collision", 64'(d_col), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file. It is the flop-based successor to the 4x8 latch-written, 2-read/1-write register file.
- Adds configurable width, depth, read-port count and write-port count.
- Adds a synchronous write with write-port priority, optional write-through bypass, optional registered read, per-entry dirty tracking, and a write-collision flag.
- Sits in the datapath holding the architectural registers (A, X, Y, S and scratch) and feeds the ALU/address buses.

Parameters:
- WIDTH, 8, data bits per entry.
- DEPTH, 4, number of entries; must be ≥2.
- NREAD, 2, number of read ports; must be ≥1.
- NWRITE, 1, number of write ports; must be 1 or 2.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return the stored value only.
- REG_READ, 0, 0 = combinational read (0-cycle latency); 1 = read output registered (1-cycle latency).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- we  in  NWRITE  per-port write enable.
- waddr  in  NWRITE*ADDRW  write addresses, port p at [p*ADDRW +: ADDRW]. ADDRW = clog2(DEPTH).
- wdata  in  NWRITE*WIDTH  write data, port p at [p*WIDTH +: WIDTH].
- raddr  in  NREAD*ADDRW  read addresses, packed the same way.
- rdata  out  NREAD*WIDTH  read data, packed the same way.
- dirty  out  DEPTH  bit i set when entry i has been written since the last clear.
- dirty_clr  in  DEPTH  per-entry synchronous clear of the dirty bits.
- collision  out  1  registered pulse: both write ports wrote the same address in the previous cycle.

Behaviour:
- Reset (async, any time, including mid-operation):
  - all entries = 0, dirty = 0, collision = 0.
  - If REG_READ=1, rdata registers = 0.
  - Reset deassertion is synchronised externally; the first write can take effect on the first posedge after deassertion.
- Write:
  - On posedge, for each p with we[p]=1, entry[waddr[p]] <= wdata[p].
  - Two ports, same address, both enabled: port 1 wins. In the same edge collision <= 1; otherwise collision <= 0.
  - Out-of-range waddr (≥DEPTH, non-power-of-2 DEPTH): the write is dropped and dirty is unchanged.
- Dirty bits:
  - On posedge: dirty[i] <= (dirty[i] & ~dirty_clr[i]) | written[i].
  - A write in the same cycle as a clear wins, so dirty stays 1.
- Read, REG_READ=0:
  - rdata[r] = entry[raddr[r]] combinationally.
  - If BYPASS=1 and some enabled write port targets raddr[r] this cycle, rdata[r] = that wdata (port 1 data on collision). This path is combinational from wdata/we/waddr to rdata.
- Read, REG_READ=1:
  - On posedge, rdata[r] <= the value the REG_READ=0 path would give (bypass rule included).
  - Result is visible 1 cycle after raddr is presented.
- Out-of-range raddr: rdata = 0.
- Read ports are independent; any number may address the same entry.
- No X propagation: every entry has a defined value after reset.

Decomposition:
- Package regfile_pkg:
  - function clog2 (returns 1 for DEPTH=2).
  - localparam defaults matching the 6502 register map: REG_A=0, REG_X=1, REG_Y=2, REG_S=3.
- Sub-module regfile_readport:
  - one read port: address decode/mux, bypass compare against NWRITE ports with port-1 priority, optional output register.
  - Generated NREAD times.
- Top holds the storage array, write/priority logic, dirty bits and the collision flop.

Test Plan:
- Reset with entries pre-written to 0x5A, reset pulsed mid-cycle -> all rdata = 0x00, dirty = 0000, collision = 0 immediately (asynchronously).
- NWRITE=2; we=11, waddr0=2, waddr1=2, wdata0=0x11, wdata1=0x22 -> entry2 = 0x22; collision = 1 for exactly one cycle; dirty[2] = 1.
- BYPASS=1, REG_READ=0; raddr0=1 while writing 0x7F to addr 1 -> rdata0 = 0x7F in the same cycle. With BYPASS=0 -> old value 0x00 that cycle, then 0x7F after the edge.
- REG_READ=1; write 0x33 to addr 3, then raddr0=3 on the next cycle -> rdata0 = 0x33 exactly one posedge later; unchanged before that edge.
- Dirty: write addr 0 with dirty_clr[0]=1 in the same cycle -> dirty[0] stays 1. Next cycle dirty_clr[0]=1 with no write -> dirty[0] = 0.
- DEPTH=6, WIDTH=16, NREAD=3:
  - write 0xBEEF to addr 5 -> all three ports read 0xBEEF.
  - write to addr 7 -> dropped, no dirty change.
  - raddr=6 -> rdata = 0x0000.
